hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning the execute latency of mult/multu in cycles.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning the execute latency of div/divu in cycles.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-005 D_rs, D_rt  input  5 each  source register numbers of the instruction in D.
REQ-006 D_tuse_rs, D_tuse_rt  input  2 each  cycles until the operand is consumed (0..2); 3 = not read.
REQ-007 E_dst, M_dst  input  5 each  destination register of the instruction in E / M; 0 = no write.
REQ-008 E_tnew, M_tnew  input  2 each  cycles until the result is ready, as seen from that stage.
REQ-009 D_is_md  input  1  the D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-010 E_md_start, E_md_is_div  input  1 each  mult/div issues from E this cycle; 1 = divide latency.
REQ-011 en_F, en_D  output  1 each  write enables of the PC and the D pipeline register.
REQ-012 clr_E  output  1  synchronous clear of the E pipeline register (bubble insert).
REQ-013 md_busy  output  1  multiply/divide unit occupied.
REQ-014 md_count  output  4  remaining MDU busy cycles.
REQ-015 stall_cnt  output  32  saturating count of stalled cycles since reset.

Function
REQ-016 Data stall SHALL assert when, for either source s in {rs,rt}, s != 0, tuse_s != 3, and (s == E_dst and tuse_s < E_tnew) or (s == M_dst and tuse_s < M_tnew).
REQ-017 MDU stall SHALL assert when D_is_md = 1 and md_busy = 1.
REQ-018 stall = data stall OR MDU stall; en_F = en_D = !stall, clr_E = stall, all combinational in the same cycle.
REQ-019 md_busy SHALL equal E_md_start OR (md_count != 0), combinationally.
REQ-020 On a clock edge with E_md_start = 1, md_count SHALL load DIV_CYCLES if E_md_is_div, else MULT_CYCLES.
REQ-021 Otherwise, md_count SHALL decrement by 1 per edge while nonzero and hold at 0.
REQ-022 E_md_start while md_count != 0 SHALL reload the counter (restart wins); upstream guarantees this does not occur.
REQ-023 A mult issued at edge t SHALL give md_busy = 1 for cycles t..t+MULT_CYCLES, then 0.
REQ-024 stall_cnt SHALL increment on each edge where stall = 1 and hold at 32'hFFFFFFFF.
REQ-025 With both sources at tuse = 3 or register 0, no data stall SHALL occur regardless of E/M destinations.

Reset
REQ-026 reset low SHALL force md_count = 0 and stall_cnt = 0 asynchronously, including mid-multiply/divide.
REQ-027 During reset, md_busy = 0 unless E_md_start = 1; en_F/en_D/clr_E follow the combinational rules.
REQ-028 The first edge after reset deasserts SHALL behave as an ordinary edge; no state survives reset.

Structure
REQ-029 A shared package hazard_pkg SHALL hold TUSE_NONE = 2'd3 and the default MULT_CYCLES/DIV_CYCLES values.
REQ-030 The MDU busy counter SHALL be a sub-module md_busy_counter (ports clk, reset, start, is_div, count, busy).
REQ-031 Stall decode SHALL be a combinational block in hazard_ctrl.

Verification
REQ-032 D_rs=8, D_tuse_rs=0, E_dst=8, E_tnew=1 -> en_F=0, en_D=0, clr_E=1 that cycle; stall_cnt +1.
REQ-033 D_rs=8, D_tuse_rs=1, M_dst=8, M_tnew=1 -> no stall; D_rs=0 with E_dst=0, E_tnew=2 -> no stall.
REQ-034 E_md_start=1, is_div=0 at edge t, D_is_md=1 after -> stall for cycles t..t+5, release at t+6.
REQ-035 div start, then reset low after 3 cycles -> md_count=0 and md_busy=0 immediately, no stall after release.
REQ-036 stall forced 5 cycles -> stall_cnt = 5; preload near saturation -> holds 32'hFFFFFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and operand-hazard helper for the hazard controller.
package hazard_pkg;

    localparam logic [1:0] TUSE_NONE       = 2'd3;
    localparam int         MULT_CYCLES_DEF = 5;
    localparam int         DIV_CYCLES_DEF  = 10;
    localparam int         MD_CNT_W        = 4;

    // Operand not yet available: a producer in E or M finishes after D needs it.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_dst,
        input logic [1:0] e_tnew,
        input logic [4:0] m_dst,
        input logic [1:0] m_tnew
    );
        logic hit;
        hit = ((src == e_dst) && (tuse < e_tnew)) ||
              ((src == m_dst) && (tuse < m_tnew));
        return (src != 5'd0) && (tuse != TUSE_NONE) && hit;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Remaining-cycle counter for the multiply/divide unit; a new start always reloads.
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                is_div,
    output logic [MD_CNT_W-1:0] count,
    output logic                busy
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (start)
            count <= is_div ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
        else if (count != '0)
            count <= count - 1'b1;
    end

    // Busy already in the issue cycle so a following md op in D is held.
    assign busy = start || (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data/MDU stall decode, bubble insert, stall statistics.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          D_rs,
    input  logic [4:0]          D_rt,
    input  logic [1:0]          D_tuse_rs,
    input  logic [1:0]          D_tuse_rt,
    input  logic [4:0]          E_dst,
    input  logic [4:0]          M_dst,
    input  logic [1:0]          E_tnew,
    input  logic [1:0]          M_tnew,
    input  logic                D_is_md,
    input  logic                E_md_start,
    input  logic                E_md_is_div,
    output logic                en_F,
    output logic                en_D,
    output logic                clr_E,
    output logic                md_busy,
    output logic [MD_CNT_W-1:0] md_count,
    output logic [31:0]         stall_cnt
);

    logic data_stall;
    logic md_stall;
    logic stall;

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_cnt (
        .clk    (clk),
        .reset  (reset),
        .start  (E_md_start),
        .is_div (E_md_is_div),
        .count  (md_count),
        .busy   (md_busy)
    );

    always_comb begin
        data_stall = src_hazard(D_rs, D_tuse_rs, E_dst, E_tnew, M_dst, M_tnew) ||
                     src_hazard(D_rt, D_tuse_rt, E_dst, E_tnew, M_dst, M_tnew);
        md_stall   = D_is_md && md_busy;
        stall      = data_stall || md_stall;
        en_F       = !stall;
        en_D       = !stall;
        clr_E      = stall;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a cycle-numbered reference model.
module tb_hazard_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_dst, M_dst;
    logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic       D_is_md, E_md_start, E_md_is_div;
    logic       en_F, en_D, clr_E, md_busy;
    logic [3:0] md_count;
    logic [31:0] stall_cnt;

    hazard_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .E_dst(E_dst), .M_dst(M_dst), .E_tnew(E_tnew), .M_tnew(M_tnew),
        .D_is_md(D_is_md), .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
        .en_F(en_F), .en_D(en_D), .clr_E(clr_E), .md_busy(md_busy),
        .md_count(md_count), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the MDU is busy through absolute cycle md_last.
    longint cyc     = 0;
    longint md_last = -1;
    longint scnt    = 0;
    bit     exp_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit operand_blocked(input int src, input int tuse);
        if (src == 0 || tuse == 3) return 0;
        if (src == int'(E_dst) && tuse < int'(E_tnew)) return 1;
        if (src == int'(M_dst) && tuse < int'(M_tnew)) return 1;
        return 0;
    endfunction

    // Check the current cycle, then let one rising edge happen and advance the model.
    task automatic step();
        longint rem;
        bit     busy;
        #1;
        rem  = (cyc <= md_last) ? (md_last - cyc + 1) : 0;
        busy = E_md_start || (rem != 0);
        exp_stall = operand_blocked(D_rs, D_tuse_rs) || operand_blocked(D_rt, D_tuse_rt) ||
                    (D_is_md && busy);
        chk("en_F",      {31'd0, en_F},    {31'd0, !exp_stall});
        chk("en_D",      {31'd0, en_D},    {31'd0, !exp_stall});
        chk("clr_E",     {31'd0, clr_E},   {31'd0, exp_stall});
        chk("md_busy",   {31'd0, md_busy}, {31'd0, busy});
        chk("md_count",  {28'd0, md_count}, 32'(rem));
        chk("stall_cnt", stall_cnt,        32'(scnt));
        @(posedge clk);
        if (reset) begin
            if (E_md_start) md_last = cyc + (E_md_is_div ? DC : MC);
            if (exp_stall && scnt < 64'hFFFF_FFFF) scnt++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        D_rs = 0; D_rt = 0; D_tuse_rs = 3; D_tuse_rt = 3;
        E_dst = 0; M_dst = 0; E_tnew = 0; M_tnew = 0;
        D_is_md = 0; E_md_start = 0; E_md_is_div = 0;
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] regs [4] = '{5'd0, 5'd1, 5'd8, 5'd9};
        return regs[$urandom_range(3)];
    endfunction

    initial begin
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_md_count",  {28'd0, md_count}, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_md_busy",   {31'd0, md_busy}, 32'd0);
        chk("rst_en_F",      {31'd0, en_F}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        step();

        // E producer not ready for a tuse=0 consumer
        D_rs = 8; D_tuse_rs = 0; E_dst = 8; E_tnew = 1;
        #1;
        chk("dir_raw_en_F", {31'd0, en_F}, 32'd0);
        chk("dir_raw_clrE", {31'd0, clr_E}, 32'd1);
        step();
        chk("dir_raw_cnt", stall_cnt, 32'd1);

        // M producer just in time, and a register-0 source
        idle_inputs();
        D_rs = 8; D_tuse_rs = 1; M_dst = 8; M_tnew = 1;
        step();
        idle_inputs();
        D_rs = 0; D_tuse_rs = 0; E_dst = 0; E_tnew = 2;
        step();

        // mult at edge t blocks a following md op through t+5
        idle_inputs();
        D_is_md = 1; E_md_start = 1;
        step();
        E_md_start = 0;
        repeat (6) step();
        chk("dir_mult_release", {31'd0, en_F}, 32'd1);

        // reset in the middle of a divide
        idle_inputs();
        E_md_start = 1; E_md_is_div = 1;
        step();
        idle_inputs();
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("dir_midrst_count", {28'd0, md_count}, 32'd0);
        chk("dir_midrst_busy",  {31'd0, md_busy}, 32'd0);
        md_last = -1; scnt = 0;
        step();
        reset = 1'b1;
        D_is_md = 1;
        step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            D_rs = pick_reg(); D_rt = pick_reg();
            D_tuse_rs = 2'($urandom_range(3)); D_tuse_rt = 2'($urandom_range(3));
            E_dst = pick_reg(); M_dst = pick_reg();
            E_tnew = 2'($urandom_range(3)); M_tnew = 2'($urandom_range(3));
            D_is_md = 1'($urandom_range(1));
            E_md_start = (cyc > md_last) && ($urandom_range(7) == 0);
            E_md_is_div = 1'($urandom_range(1));
            step();
        end

        // five forced stalls from a clean counter
        idle_inputs();
        reset = 1'b0;
        md_last = -1; scnt = 0;
        step();
        reset = 1'b1;
        D_rs = 8; D_tuse_rs = 0; E_dst = 8; E_tnew = 1;
        repeat (5) step();
        chk("dir_five_stalls", stall_cnt, 32'd5);

        // saturation: preload just below the top and keep stalling
        dut.stall_cnt = 32'hFFFF_FFFD;
        scnt = 64'hFFFF_FFFD;
        repeat (5) step();
        chk("dir_saturate", stall_cnt, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
